// File: rtl/prescaled_updown_counter_pkg.sv
// counter_pkg: shared constants and helpers for the prescaled up/down counter
// and the blocks that reuse its tick prescaler.
package counter_pkg;

    // Direction encoding for the up_dn input.
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Default build parameters for the board-level display counters.
    localparam int DEF_WIDTH    = 4;
    localparam int DEF_MODULUS  = 16;
    localparam int DEF_DIV_BITS = 23;

    // Clamp a requested load value into the legal count range 0..modulus-1.
    function automatic logic [31:0] clamp_load(input logic [31:0] val,
                                               input logic [31:0] modulus);
        logic [31:0] max_v;
        max_v = modulus - 32'd1;
        if (val > max_v) begin
            return max_v;
        end else begin
            return val;
        end
    endfunction

endpackage

// File: rtl/prescaled_updown_counter_tick_prescaler.sv
// tick_prescaler: free-running DIV_BITS-bit divider that emits a one-cycle
// enable strobe each time it reaches all-ones. Shared with the display-refresh
// and debounce blocks; no derived clocks are produced.
module tick_prescaler #(
    parameter int DIV_BITS = 23
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam logic [DIV_BITS-1:0] ONE_C  = DIV_BITS'(1);
    localparam logic [DIV_BITS-1:0] ZERO_C = {DIV_BITS{1'b0}};
    localparam logic [DIV_BITS-1:0] ONES_C = {DIV_BITS{1'b1}};

    logic [DIV_BITS-1:0] pre_r;

    // Divider register: cleared by reset, otherwise wraps naturally.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pre_r <= ZERO_C;
        end else begin
            pre_r <= pre_r + ONE_C;
        end
    end

    // The strobe is decoded directly from the divider and forced low in reset.
    assign tick = reset & (pre_r == ONES_C);

endmodule

// File: rtl/prescaled_updown_counter.sv
// prescaled_updown_counter: WIDTH-bit up/down modulo counter stepped by an
// internal prescaler strobe, with synchronous load and a terminal-count pulse.
// Build option: define PRESCALED_COUNTER_SATURATE_EN to saturate at the range
// limits instead of wrapping.
module prescaled_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MODULUS  = DEF_MODULUS,
    parameter int DIV_BITS = DEF_DIV_BITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);
    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MODULUS - 1);

    logic             tick_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_next_s;
    logic             tc_r;
    logic             tc_next_s;

    tick_prescaler #(
        .DIV_BITS(DIV_BITS)
    ) u_tick_prescaler (
        .clk  (clk),
        .reset(reset),
        .tick (tick_s)
    );

    // Next-state: reset > load > (tick & en) > hold; tc only survives one cycle.
    always_comb begin
        count_next_s = count_r;
        tc_next_s    = 1'b0;
        if (!reset) begin
            count_next_s = ZERO_C;
            tc_next_s    = 1'b0;
        end else if (load) begin
            count_next_s = WIDTH'(clamp_load(32'(load_val), 32'(MODULUS)));
            tc_next_s    = 1'b0;
        end else if (tick_s && en) begin
            if (up_dn == DIR_UP) begin
`ifdef PRESCALED_COUNTER_SATURATE_EN
                if (count_r == MAX_C) begin
                    count_next_s = count_r;
                    tc_next_s    = 1'b0;
                end else begin
                    count_next_s = count_r + ONE_C;
                    tc_next_s    = (count_r == (MAX_C - ONE_C));
                end
`else
                if (count_r == MAX_C) begin
                    count_next_s = ZERO_C;
                    tc_next_s    = 1'b1;
                end else begin
                    count_next_s = count_r + ONE_C;
                    tc_next_s    = 1'b0;
                end
`endif
            end else begin
`ifdef PRESCALED_COUNTER_SATURATE_EN
                if (count_r == ZERO_C) begin
                    count_next_s = count_r;
                    tc_next_s    = 1'b0;
                end else begin
                    count_next_s = count_r - ONE_C;
                    tc_next_s    = (count_r == ONE_C);
                end
`else
                if (count_r == ZERO_C) begin
                    count_next_s = MAX_C;
                    tc_next_s    = 1'b1;
                end else begin
                    count_next_s = count_r - ONE_C;
                    tc_next_s    = 1'b0;
                end
`endif
            end
        end else begin
            count_next_s = count_r;
            tc_next_s    = 1'b0;
        end
    end

    // State registers; reset is already folded into the next-state logic.
    always_ff @(posedge clk) begin
        count_r <= count_next_s;
        tc_r    <= tc_next_s;
    end

    assign count = count_r;
    assign tc    = tc_r;
    assign tick  = tick_s;

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// Self-checking bench: two counters (MODULUS 10 and 16, DIV_BITS 2) share the
// same stimulus and are compared each cycle against an arithmetic model.
module tb_prescaled_updown_counter;

    logic       clk = 1'b0;
    logic       reset, en, up_dn, load;
    logic [3:0] load_val;
    logic [3:0] count10, count16;
    logic       tick10, tick16, tc10, tc16;

    int n_asserts = 0;
    int n_fails   = 0;

    // model state
    int m_pre;
    int m_c10, m_c16;
    bit m_tc10, m_tc16;

    always #5 clk = ~clk;

    prescaled_updown_counter #(.WIDTH(4), .MODULUS(10), .DIV_BITS(2)) dut10 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .count(count10), .tick(tick10), .tc(tc10));

    prescaled_updown_counter #(.WIDTH(4), .MODULUS(16), .DIV_BITS(2)) dut16 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .count(count16), .tick(tick16), .tc(tc16));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One modulo-m counter updated by the rules for a single clock edge.
    function automatic void mdl_cnt(input int m, inout int c, inout bit t, input bit tk);
        if (!reset) begin
            c = 0; t = 0;
        end else if (load) begin
            c = (int'(load_val) > m - 1) ? m - 1 : int'(load_val);
            t = 0;
        end else if (tk && en) begin
`ifdef PRESCALED_COUNTER_SATURATE_EN
            if (up_dn) begin
                t = (c == m - 2);
                if (c < m - 1) c = c + 1;
            end else begin
                t = (c == 1);
                if (c > 0) c = c - 1;
            end
`else
            if (up_dn) begin
                t = (c == m - 1);
                c = (c + 1) % m;
            end else begin
                t = (c == 0);
                c = (c + m - 1) % m;
            end
`endif
        end else begin
            t = 0;
        end
    endfunction

    // Advance one clock: check tick before the edge, then count/tc after it.
    task automatic cyc();
        bit tk;
        #1;
        tk = reset && (m_pre == 3);
        chk("tick10", 32'(tick10), 32'(tk));
        chk("tick16", 32'(tick16), 32'(tk));
        mdl_cnt(10, m_c10, m_tc10, tk);
        mdl_cnt(16, m_c16, m_tc16, tk);
        m_pre = reset ? (m_pre + 1) % 4 : 0;
        @(posedge clk);
        #1;
        chk("count10", 32'(count10), 32'(m_c10));
        chk("tc10",    32'(tc10),    32'(m_tc10));
        chk("count16", 32'(count16), 32'(m_c16));
        chk("tc16",    32'(tc16),    32'(m_tc16));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 4'd0;
        m_pre = 0; m_c10 = 0; m_c16 = 0; m_tc10 = 0; m_tc16 = 0;
        @(negedge clk);
        run(2);
        chk("reset_count10", 32'(count10), 32'd0);
        chk("reset_tc10",    32'(tc10),    32'd0);

        // count up across a full 0..9,0 sequence
        reset = 1'b1; en = 1'b1; up_dn = 1'b1;
        run(44);

        // down from 0: wraps to 9 with tc, then 8, 7
        load = 1'b1; load_val = 4'd0;
        cyc();
        chk("load0_count10", 32'(count10), 32'd0);
        load = 1'b0; up_dn = 1'b0;
        run(12);

        // oversize load clamps to MODULUS-1
        load = 1'b1; load_val = 4'd12;
        cyc();
        chk("clamp_count10", 32'(count10), 32'd9);
        chk("clamp_count16", 32'(count16), 32'd12);
        load = 1'b0; up_dn = 1'b1;

        // load coincident with tick wins over the step
        while (m_pre != 3) cyc();
        load = 1'b1; load_val = 4'd5;
        cyc();
        chk("loadtick_count10", 32'(count10), 32'd5);
        chk("loadtick_tc10",    32'(tc10),    32'd0);
        load = 1'b0;

        // disabled across three ticks: holds
        en = 1'b0;
        run(12);
        chk("hold_count10", 32'(count10), 32'd5);

        // reset mid-run, also aborting a pending load
        en = 1'b1;
        run(6);
        reset = 1'b0; load = 1'b1; load_val = 4'd7;
        cyc();
        chk("midreset_count10", 32'(count10), 32'd0);
        reset = 1'b1; load = 1'b0;
        run(9);

        // top-of-range wrap (or saturation) on both moduli
        load = 1'b1; load_val = 4'd8;
        cyc();
        load = 1'b0; up_dn = 1'b1;
        run(16);
        load = 1'b1; load_val = 4'd14;
        cyc();
        load = 1'b0;
        run(12);
        load = 1'b1; load_val = 4'd1;
        cyc();
        load = 1'b0; up_dn = 1'b0;
        run(16);

        // randomized phase
        for (int i = 0; i < 400; i++) begin
            en       = ($urandom % 4) != 0;
            up_dn    = $urandom % 2;
            load     = ($urandom % 16) == 0;
            load_val = 4'($urandom % 16);
            reset    = ($urandom % 64) != 0;
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
